id_hazard_ctrl: RTL and testbench

Scoreboard-based hazard controller for the ID stage. It tracks, per architectural register, how many issued instructions still owe a write-back. It stalls the instruction in ID when a source operand, or a destination slot, is not yet safe. It sits beside the decoder and register file: it reads the decoder's rs/rd fields, drives the stall that holds the IF-ID register and bubbles the ID-EX register, and retires entries from the register-file write port.

---
 rtl/id_hazard_ctrl_if.sv | 34 +++
 rtl/id_hazard_ctrl.sv | 70 +++++++
 tb/tb_id_hazard_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/id_hazard_ctrl_if.sv
// Handshake bundle between the ID-stage decoder/register-file side (master)
// and the scoreboard hazard controller (slave).
interface id_hazard_ctrl_if #(
  parameter int MAX_INFLIGHT = 3
);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  logic          id_valid_i;
  logic [4:0]    rs1_addr_i;
  logic          rs1_used_i;
  logic [4:0]    rs2_addr_i;
  logic          rs2_used_i;
  logic [4:0]    rd_addr_i;
  logic          rd_wr_en_i;
  logic          wb_we_i;
  logic [4:0]    wb_waddr_i;
  logic          flush_i;
  logic          id_stall_o;
  logic          id_issue_o;
  logic [CW-1:0] inflight_o;
  logic          wb_err_o;

  modport master (
    output id_valid_i, rs1_addr_i, rs1_used_i, rs2_addr_i, rs2_used_i,
           rd_addr_i, rd_wr_en_i, wb_we_i, wb_waddr_i, flush_i,
    input  id_stall_o, id_issue_o, inflight_o, wb_err_o
  );

  modport slave (
    input  id_valid_i, rs1_addr_i, rs1_used_i, rs2_addr_i, rs2_used_i,
           rd_addr_i, rd_wr_en_i, wb_we_i, wb_waddr_i, flush_i,
    output id_stall_o, id_issue_o, inflight_o, wb_err_o
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// Scoreboard hazard controller for the ID stage: per-register pending-write
// counters drive RAW and write-slot stalls; write-backs retire entries.
module id_hazard_ctrl #(
  parameter int MAX_INFLIGHT = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  id_hazard_ctrl_if.slave  bus
);
  localparam int            CW      = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);
  localparam logic [CW-1:0] ONE     = CW'(1);

  // Entry 0 exists only so the array can be indexed by any 5-bit address;
  // it is cleared on reset and never written afterwards.
  logic [CW-1:0] cnt [32];
  logic [CW-1:0] total;
  logic          wb_err;

  logic raw1, raw2, wsat, stall, issue;
  logic inc, dec, spurious;
  logic rd_nz, wb_nz;

  assign rd_nz = (bus.rd_addr_i  != 5'd0);
  assign wb_nz = (bus.wb_waddr_i != 5'd0);

  assign raw1 = bus.rs1_used_i && (bus.rs1_addr_i != 5'd0) && (cnt[bus.rs1_addr_i] != '0);
  assign raw2 = bus.rs2_used_i && (bus.rs2_addr_i != 5'd0) && (cnt[bus.rs2_addr_i] != '0);
  assign wsat = bus.rd_wr_en_i && rd_nz &&
                ((cnt[bus.rd_addr_i] == MAX_CNT) || (total == MAX_CNT));

  // Hazards use the pre-edge scoreboard only: a same-cycle write-back does
  // not release the stall because the register file has no write-through.
  assign stall = bus.id_valid_i && !bus.flush_i && (raw1 || raw2 || wsat);
  assign issue = bus.id_valid_i && !stall && !bus.flush_i;

  assign inc      = issue && bus.rd_wr_en_i && rd_nz;
  assign dec      = bus.wb_we_i && wb_nz && (cnt[bus.wb_waddr_i] != '0);
  assign spurious = bus.wb_we_i && wb_nz && (cnt[bus.wb_waddr_i] == '0);

  assign bus.id_stall_o = stall;
  assign bus.id_issue_o = issue;
  assign bus.inflight_o = total;
  assign bus.wb_err_o   = wb_err;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // counter sees the pre-edge value of its neighbours regardless of order.
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) begin
      // NOTE: the counter array is reset, not left uninitialised; a stale
      // nonzero entry would stall its register forever.
      for (int r = 0; r < 32; r++) cnt[r] <= '0;
      total  <= '0;
      wb_err <= 1'b0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (inc && (bus.rd_addr_i == 5'(r)) && !(dec && (bus.wb_waddr_i == 5'(r))))
          cnt[r] <= cnt[r] + ONE;
        else if (dec && (bus.wb_waddr_i == 5'(r)) && !(inc && (bus.rd_addr_i == 5'(r))))
          cnt[r] <= cnt[r] - ONE;
      end
      // Increment cannot overflow: WSAT blocks issue at MAX_CNT.
      if (inc && !dec)
        total <= total + ONE;
      else if (dec && !inc)
        total <= total - ONE;
      wb_err <= spurious;
    end
  end
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl: directed scenarios followed by
// random traffic compared against a pending-write list model.
module tb_id_hazard_ctrl;
  localparam int MAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_hazard_ctrl_if #(.MAX_INFLIGHT(MAX)) bus ();
  id_hazard_ctrl #(.MAX_INFLIGHT(MAX)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: number of outstanding writes owed to each register.
  int pend [32];
  bit exp_err;
  int saved;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2,
                        input bit u2, input int rd, input bit we);
    bus.id_valid_i = v;
    bus.rs1_addr_i = 5'(rs1); bus.rs1_used_i = u1;
    bus.rs2_addr_i = 5'(rs2); bus.rs2_used_i = u2;
    bus.rd_addr_i  = 5'(rd);  bus.rd_wr_en_i = we;
  endtask

  task automatic set_wb(input bit we, input int a);
    bus.wb_we_i = we; bus.wb_waddr_i = 5'(a);
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0);
    bus.flush_i = 1'b0;
  endtask

  function automatic int pend_total();
    int s = 0;
    foreach (pend[i]) s += pend[i];
    return s;
  endfunction

  // One clock: compare every output with the model, then apply this cycle's
  // effects to the model. Called at the negedge with inputs already driven.
  task automatic step(input string tag);
    bit exp_stall, exp_issue, retire;
    int s, r1, r2, rd, wa;
    #1;
    s  = pend_total();
    r1 = int'(bus.rs1_addr_i); r2 = int'(bus.rs2_addr_i);
    rd = int'(bus.rd_addr_i);  wa = int'(bus.wb_waddr_i);
    exp_stall = bus.id_valid_i && !bus.flush_i &&
                ((bus.rs1_used_i && r1 != 0 && pend[r1] > 0) ||
                 (bus.rs2_used_i && r2 != 0 && pend[r2] > 0) ||
                 (bus.rd_wr_en_i && rd != 0 && (pend[rd] == MAX || s == MAX)));
    exp_issue = bus.id_valid_i && !exp_stall && !bus.flush_i;
    check({tag, "/stall"},    8'(bus.id_stall_o), 8'(exp_stall));
    check({tag, "/issue"},    8'(bus.id_issue_o), 8'(exp_issue));
    check({tag, "/inflight"}, 8'(bus.inflight_o), 8'(s));
    check({tag, "/wb_err"},   8'(bus.wb_err_o),   8'(exp_err));
    @(posedge clk);
    if (rst || bus.flush_i) begin
      foreach (pend[i]) pend[i] = 0;
      exp_err = 1'b0;
    end else begin
      retire  = bus.wb_we_i && wa != 0 && pend[wa] > 0;
      exp_err = bus.wb_we_i && wa != 0 && pend[wa] == 0;
      if (exp_issue && bus.rd_wr_en_i && rd != 0) pend[rd]++;
      if (retire) pend[wa]--;
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    foreach (pend[i]) pend[i] = 0;
    exp_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset/inflight", 8'(bus.inflight_o), 8'd0);
    check("reset/wb_err",   8'(bus.wb_err_o),   8'd0);
    check("reset/stall",    8'(bus.id_stall_o), 8'd0);
    check("reset/issue",    8'(bus.id_issue_o), 8'd0);

    // Back-to-back dependency on x5.
    set_id(1, 0, 0, 0, 0, 5, 1); step("raw_issue");
    set_id(1, 5, 1, 0, 0, 10, 1);
    #1 check("raw/stall", 8'(bus.id_stall_o), 8'd1);
    check("raw/inflight", 8'(bus.inflight_o), 8'd1);
    step("raw_wait");
    set_wb(1, 5);
    #1 check("raw/stall_wb_cycle", 8'(bus.id_stall_o), 8'd1);
    step("raw_wb");
    set_wb(0, 0);
    #1 check("raw/release_issue", 8'(bus.id_issue_o), 8'd1);
    check("raw/release_inflight", 8'(bus.inflight_o), 8'd0);
    step("raw_release");
    idle(); set_wb(1, 10); step("raw_drain");

    // x0 is never tracked.
    idle(); set_id(1, 0, 0, 0, 0, 0, 1); step("x0_write");
    set_id(1, 0, 1, 0, 1, 0, 0);
    #1 check("x0/stall", 8'(bus.id_stall_o), 8'd0);
    check("x0/inflight", 8'(bus.inflight_o), 8'd0);
    step("x0_read");
    idle(); set_wb(1, 0); step("x0_wb");
    idle(); step("x0_after");
    check("x0/wb_err", 8'(bus.wb_err_o), 8'd0);

    // Saturation of the total count.
    set_id(1, 0, 0, 0, 0, 1, 1); step("sat_x1");
    set_id(1, 0, 0, 0, 0, 2, 1); step("sat_x2");
    set_id(1, 0, 0, 0, 0, 3, 1); step("sat_x3");
    set_id(1, 0, 0, 0, 0, 4, 1);
    #1 check("sat/inflight3", 8'(bus.inflight_o), 8'd3);
    check("sat/stall_x4", 8'(bus.id_stall_o), 8'd1);
    step("sat_x4_blocked");
    set_wb(1, 2); step("sat_wb2");
    set_wb(0, 0);
    #1 check("sat/x4_issue", 8'(bus.id_issue_o), 8'd1);
    step("sat_x4_issue");
    check("sat/inflight_after", 8'(bus.inflight_o), 8'd3);
    idle(); bus.flush_i = 1'b1; step("sat_flush");

    // Issue and retire of the same register in one cycle.
    idle(); set_id(1, 0, 0, 0, 0, 7, 1); step("same_setup");
    set_wb(1, 7); step("same_both");
    idle(); set_id(1, 7, 1, 0, 0, 8, 1);
    #1 check("same/inflight", 8'(bus.inflight_o), 8'd1);
    check("same/reader_stall", 8'(bus.id_stall_o), 8'd1);
    step("same_reader");
    idle(); bus.flush_i = 1'b1; step("same_flush");

    // Flush while writes are pending.
    idle(); set_id(1, 0, 0, 0, 0, 3, 1); step("fl_x3");
    set_id(1, 0, 0, 0, 0, 9, 1); step("fl_x9");
    check("flush/inflight2", 8'(bus.inflight_o), 8'd2);
    idle(); bus.flush_i = 1'b1; set_wb(1, 3); step("fl_flush");
    idle(); set_id(1, 9, 1, 0, 0, 0, 0);
    #1 check("flush/inflight0", 8'(bus.inflight_o), 8'd0);
    check("flush/wb_err", 8'(bus.wb_err_o), 8'd0);
    check("flush/reader_issue", 8'(bus.id_issue_o), 8'd1);
    step("fl_reader");

    // Spurious write-back raises a single-cycle error pulse.
    idle(); set_id(1, 0, 0, 0, 0, 6, 1); step("sp_setup");
    idle(); saved = int'(bus.inflight_o); set_wb(1, 12); step("sp_wb");
    idle();
    #1 check("spur/wb_err_pulse", 8'(bus.wb_err_o), 8'd1);
    check("spur/inflight", 8'(bus.inflight_o), 8'(saved));
    step("sp_pulse");
    check("spur/wb_err_clear", 8'(bus.wb_err_o), 8'd0);

    // Reset mid-operation discards pending state, even against a flush/issue.
    set_id(1, 0, 0, 0, 0, 11, 1); step("rst_pre");
    rst = 1'b1; set_wb(1, 12); step("rst_edge");
    rst = 1'b0; idle();
    #1 check("rst/inflight", 8'(bus.inflight_o), 8'd0);
    check("rst/wb_err", 8'(bus.wb_err_o), 8'd0);

    // Random traffic on a small register window so hazards occur often.
    for (int n = 0; n < 1500; n++) begin
      set_id(1'($urandom_range(0, 3) != 0),
             int'($urandom_range(0, 7)), 1'($urandom),
             int'($urandom_range(0, 7)), 1'($urandom),
             int'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
      set_wb(1'($urandom), int'($urandom_range(0, 7)));
      bus.flush_i = ($urandom_range(0, 40) == 0);
      rst         = ($urandom_range(0, 300) == 0);
      step("rnd");
    end
    rst = 1'b0; idle(); step("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
